gcd_host_word_packer: RTL and testbench

//  Sits directly upstream of HostGcdUnit_SwShim. Accepts a 16-bit host word stream (operand A, then B).

---
 rtl/gcd_host_word_packer.sv | 176 +++++++++++++++++
 tb/tb_gcd_host_word_packer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_host_word_packer.sv
// gcd_host_word_packer
//   Takes a stream of 16-bit host words (operand A, then operand B) and packs
//   each pair into a 32-bit GCD request {A, B}. Requests wait in a small FIFO.
//   A credit counter limits how many requests may be issued to the GCD unit
//   before their responses have been handed back to the host. Responses pass
//   straight through to the host. The block also keeps request and response
//   counters and a sticky protocol-error flag.
//
// Parameters
//   p_depth            request FIFO entries (power of two, >= 2)
//   p_max_outstanding  max issued-but-undelivered requests (1..255)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   in_val/in_rdy/in_msg        host word stream (A first, then B)
//   req_val/req_rdy/req_msg     32-bit request to the GCD unit
//   gcd_resp_val/rdy/msg        16-bit result from the GCD unit
//   out_val/out_rdy/out_msg     16-bit result to the host
//   busy                        partial pair held, FIFO non-empty, or credits in use
//   err                         sticky: response delivered with nothing outstanding
//   req_count, resp_count       wrapping 16-bit fire counters
module gcd_host_word_packer #(
  parameter int p_depth           = 4,
  parameter int p_max_outstanding = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [15:0] in_msg,
  output logic        req_val,
  input  logic        req_rdy,
  output logic [31:0] req_msg,
  input  logic        gcd_resp_val,
  output logic        gcd_resp_rdy,
  input  logic [15:0] gcd_resp_msg,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [15:0] out_msg,
  output logic        busy,
  output logic        err,
  output logic [15:0] req_count,
  output logic [15:0] resp_count
);

  localparam int AW = $clog2(p_depth);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(p_depth);
  localparam logic [7:0]  MAX_C   = 8'(p_max_outstanding);

  typedef enum logic {
    S_A = 1'b0,
    S_B = 1'b1
  } state_e;

  state_e          state_q;
  logic [15:0]     a_q;
  logic [31:0]     mem_q [p_depth];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic [7:0]      outst_q;
  logic [7:0]      outst_d;
  logic            err_q;
  logic            err_d;
  logic [15:0]     req_count_q;
  logic [15:0]     resp_count_q;

  logic            full;
  logic            empty;
  logic            in_fire;
  logic            push;
  logic            req_fire;
  logic            out_fire;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);

  // In S_A the word is only latched, so it never needs FIFO space.
  assign in_rdy   = (state_q == S_A) || !full;
  assign in_fire  = in_val && in_rdy;
  assign push     = in_fire && (state_q == S_B);

  // The FIFO is tiny, so the head is read asynchronously; that keeps the
  // request visible the cycle after B is accepted.
  assign req_val  = !empty && (outst_q < MAX_C);
  assign req_msg  = mem_q[head_q];
  assign req_fire = req_val && req_rdy;

  // Response path is a pure wire-through.
  assign out_val      = gcd_resp_val;
  assign gcd_resp_rdy = out_rdy;
  assign out_msg      = gcd_resp_msg;
  assign out_fire     = gcd_resp_val && out_rdy;

  assign busy       = (state_q == S_B) || !empty || (outst_q != '0);
  assign err        = err_q;
  assign req_count  = req_count_q;
  assign resp_count = resp_count_q;

  always_comb begin
    count_d = count_q;
    case ({push, req_fire})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Simultaneous issue and delivery cancel out. A delivery with no credit
  // in use is a protocol violation: flag it and keep the count pinned at 0.
  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    if (req_fire && !out_fire) begin
      outst_d = outst_q + 8'd1;
    end else if (out_fire && !req_fire) begin
      if (outst_q == '0) begin
        err_d = 1'b1;
      end else begin
        outst_d = outst_q - 8'd1;
      end
    end
  end

  // Storage has no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= {a_q, in_msg};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_A;
      a_q          <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      err_q        <= 1'b0;
      req_count_q  <= '0;
      resp_count_q <= '0;
    end else begin
      case (state_q)
        S_A: begin
          if (in_fire) begin
            a_q     <= in_msg;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (in_fire) begin
            state_q <= S_A;
          end
        end
        default: state_q <= S_A;
      endcase

      if (push) begin
        tail_q <= tail_q + AW'(1);
      end
      if (req_fire) begin
        head_q      <= head_q + AW'(1);
        req_count_q <= req_count_q + 16'd1;
      end
      if (out_fire) begin
        resp_count_q <= resp_count_q + 16'd1;
      end
      count_q <= count_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gcd_host_word_packer.sv
module tb_gcd_host_word_packer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] in_msg;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_msg;
  logic        gcd_resp_val;
  logic        gcd_resp_rdy;
  logic [15:0] gcd_resp_msg;
  logic        out_val;
  logic        out_rdy;
  logic [15:0] out_msg;
  logic        busy;
  logic        err;
  logic [15:0] req_count;
  logic [15:0] resp_count;

  gcd_host_word_packer #(
    .p_depth(DEPTH),
    .p_max_outstanding(MAXO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_val(in_val),
    .in_rdy(in_rdy),
    .in_msg(in_msg),
    .req_val(req_val),
    .req_rdy(req_rdy),
    .req_msg(req_msg),
    .gcd_resp_val(gcd_resp_val),
    .gcd_resp_rdy(gcd_resp_rdy),
    .gcd_resp_msg(gcd_resp_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg),
    .busy(busy),
    .err(err),
    .req_count(req_count),
    .resp_count(resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus controls (written by the main sequence)
  int dly     = 0;
  bit req_en  = 1'b1;
  bit sink_en = 1'b1;
  bit inject  = 1'b0;

  // host source, GCD-unit stand-in, and delivery logs
  logic [15:0] src_q[$];
  logic [15:0] pending[$];
  logic [15:0] got[$];
  logic [31:0] reqs[$];

  // behavioural model of the packer
  bit          m_have_a = 1'b0;
  logic [15:0] m_a      = '0;
  logic [31:0] m_fifo[$];
  int          m_out    = 0;
  bit          m_err    = 1'b0;
  logic [15:0] m_reqc   = '0;
  logic [15:0] m_respc  = '0;

  logic [15:0] t2_a [5] = '{16'd27, 16'd49, 16'd0, 16'd5, 16'd1};
  logic [15:0] t2_b [5] = '{16'd15, 16'd28, 16'd7, 16'd0, 16'd1};
  logic [15:0] t2_r [5] = '{16'd3, 16'd7, 16'd7, 16'd5, 16'd1};
  logic [15:0] t3_a [5] = '{16'd12, 16'd100, 16'd17, 16'd64, 16'd9};
  logic [15:0] t3_b [5] = '{16'd18, 16'd75, 16'd5, 16'd48, 16'd9};
  logic [15:0] t3_r [5] = '{16'd6, 16'd25, 16'd1, 16'd16, 16'd9};
  logic [15:0] t4_a [3] = '{16'd6, 16'd10, 16'd9};
  logic [15:0] t4_b [3] = '{16'd4, 16'd4, 16'd6};
  logic [15:0] t4_r [3] = '{16'd2, 16'd2, 16'd3};

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic bit rnd();
    return ($urandom_range(0, dly) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then model/stimulus update, then drive.
  initial begin
    bit          inf;
    bit          rqf;
    bit          of;
    bit          exp_req_val;
    logic [31:0] pair;
    logic [15:0] dummy;
    forever begin
      @(negedge clk);
      exp_req_val = (m_fifo.size() > 0) && (m_out < MAXO);
      chk("in_rdy", in_rdy, (!m_have_a || m_fifo.size() < DEPTH) ? 1 : 0);
      chk("req_val", req_val, exp_req_val ? 1 : 0);
      if (exp_req_val) chk("req_msg", req_msg, m_fifo[0]);
      chk("busy", busy, (m_have_a || m_fifo.size() != 0 || m_out != 0) ? 1 : 0);
      chk("err", err, m_err ? 1 : 0);
      chk("req_count", req_count, m_reqc);
      chk("resp_count", resp_count, m_respc);
      chk("out_val", out_val, gcd_resp_val);
      chk("gcd_resp_rdy", gcd_resp_rdy, out_rdy);
      chk("out_msg", out_msg, gcd_resp_msg);

      inf = in_val && in_rdy;
      rqf = req_val && req_rdy;
      of  = out_val && out_rdy;

      if (reset) begin
        m_have_a = 1'b0;
        m_fifo.delete();
        m_out    = 0;
        m_err    = 1'b0;
        m_reqc   = '0;
        m_respc  = '0;
        pending.delete();
      end else begin
        if (rqf && m_fifo.size() > 0) begin
          pair = m_fifo.pop_front();
          reqs.push_back(req_msg);
          pending.push_back(gcd16(pair[31:16], pair[15:0]));
          m_reqc = m_reqc + 16'd1;
        end
        if (of) begin
          m_respc = m_respc + 16'd1;
          got.push_back(out_msg);
          if (!inject && pending.size() > 0) dummy = pending.pop_front();
        end
        if (rqf && !of) begin
          m_out++;
        end else if (of && !rqf) begin
          if (m_out == 0) m_err = 1'b1;
          else m_out--;
        end
        if (inf) begin
          if (m_have_a) begin
            m_fifo.push_back({m_a, in_msg});
            m_have_a = 1'b0;
          end else begin
            m_a      = in_msg;
            m_have_a = 1'b1;
          end
          if (src_q.size() > 0) dummy = src_q.pop_front();
        end
      end

      @(posedge clk);
      #1;
      in_val  = (src_q.size() > 0) && rnd();
      in_msg  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
      req_rdy = req_en && rnd();
      if (inject) begin
        gcd_resp_val = 1'b1;
        gcd_resp_msg = 16'hBEEF;
      end else if (pending.size() > 0) begin
        gcd_resp_val = rnd();
        gcd_resp_msg = pending[0];
      end else begin
        gcd_resp_val = 1'b0;
        gcd_resp_msg = 16'h0000;
      end
      out_rdy = sink_en && rnd();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    got.delete();
    reqs.delete();
  endtask

  function automatic bit idle();
    return (src_q.size() == 0) && (pending.size() == 0) && !m_have_a &&
           (m_fifo.size() == 0) && (m_out == 0);
  endfunction

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (idle()) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy expected idle within 3000 cycles", name);
    end
  endtask

  task automatic wait_src(input string name, input int left);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (src_q.size() == left) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d words left expected %0d", name, src_q.size(), left);
    end
  endtask

  function automatic logic [15:0] got_at(input int i);
    return (got.size() > i) ? got[i] : 16'hDEAD;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish by t=300000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    in_val       = 1'b0;
    in_msg       = '0;
    req_rdy      = 1'b0;
    gcd_resp_val = 1'b0;
    gcd_resp_msg = '0;
    out_rdy      = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_req_val", req_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_req_count", req_count, 0);
    chk("rst_resp_count", resp_count, 0);

    // T1 single op
    src_q.push_back(16'h000F);
    src_q.push_back(16'h0005);
    wait_idle("t1");
    #1;
    chk("t1_req_msg", (reqs.size() > 0) ? reqs[0] : 32'hDEADDEAD, 32'h000F0005);
    chk("t1_out_msg", got_at(0), 16'h0005);
    chk("t1_req_count", req_count, 1);
    chk("t1_resp_count", resp_count, 1);
    chk("t1_busy", busy, 0);

    // T2 stream, no delay then random delay up to 3
    for (int r = 0; r < 2; r++) begin
      do_reset();
      dly = (r == 0) ? 0 : 3;
      for (int i = 0; i < 5; i++) begin
        src_q.push_back(t2_a[i]);
        src_q.push_back(t2_b[i]);
      end
      wait_idle("t2");
      #1;
      chk("t2_len", got.size(), 5);
      for (int i = 0; i < 5; i++) chk("t2_result", got_at(i), t2_r[i]);
      chk("t2_req_count", req_count, 5);
      chk("t2_resp_count", resp_count, 5);
    end
    dly = 0;

    // T3 FIFO full under request backpressure
    do_reset();
    req_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src_q.push_back(t3_a[i]);
      src_q.push_back(t3_b[i]);
    end
    wait_src("t3_fill", 1);
    repeat (3) step();
    #1;
    chk("t3_in_rdy_full", in_rdy, 0);
    chk("t3_req_val", req_val, 1);
    chk("t3_req_count", req_count, 0);
    req_en = 1'b1;
    wait_idle("t3");
    #1;
    chk("t3_len", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_result", got_at(i), t3_r[i]);

    // T4 credit limit with host sink stalled
    do_reset();
    sink_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_q.push_back(t4_a[i]);
      src_q.push_back(t4_b[i]);
    end
    repeat (12) step();
    #1;
    chk("t4_req_count_capped", req_count, 2);
    chk("t4_req_val_capped", req_val, 0);
    sink_en = 1'b1;
    step();
    sink_en = 1'b0;
    step();
    #1;
    chk("t4_one_resp", resp_count, 1);
    chk("t4_req_val_after_credit", req_val, 1);
    sink_en = 1'b1;
    wait_idle("t4");
    #1;
    chk("t4_len", got.size(), 3);
    for (int i = 0; i < 3; i++) chk("t4_result", got_at(i), t4_r[i]);
    chk("t4_req_count", req_count, 3);

    // T5 reset between A and B
    do_reset();
    src_q.push_back(16'h0030);
    wait_src("t5_a", 0);
    step();
    #1;
    chk("t5_busy_partial", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    src_q.push_back(16'h0012);
    src_q.push_back(16'h0008);
    wait_idle("t5");
    #1;
    chk("t5_req_msg", (reqs.size() > 0) ? reqs[0] : 32'hDEADDEAD, 32'h00120008);
    chk("t5_result", got_at(0), 16'h0002);
    chk("t5_req_count", req_count, 1);

    // T6 unsolicited response
    do_reset();
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (2) step();
    #1;
    chk("t6_err", err, 1);
    chk("t6_busy", busy, 0);
    chk("t6_resp_count", resp_count, 1);
    repeat (3) step();
    #1;
    chk("t6_err_sticky", err, 1);
    chk("t6_req_val", req_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
